// File: rtl/game_flow_ctrl.sv
// Rhythm-game flow controller: three debounced buttons and a chart-end flag step the game
// through MENU -> READY (countdown) -> PLAY -> RESULT.
module game_flow_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned READY_CYCLES    = 1024,
  parameter int unsigned NUM_SONGS       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_button,
  input  logic       blue_button,
  input  logic       yellow_button,
  input  logic       finish,
  output logic [1:0] state,
  output logic [1:0] song_sel,
  output logic [1:0] song_confirm,
  output logic       start
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RdyW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RdyW-1:0] RdyLast = RdyW'(READY_CYCLES - 1);
  localparam logic [1:0]      SelLast = 2'(NUM_SONGS - 1);

  typedef enum logic [1:0] {
    StMenu   = 2'b00,
    StReady  = 2'b01,
    StPlay   = 2'b10,
    StResult = 2'b11
  } state_e;

  // Button lanes: bit 0 red, bit 1 blue, bit 2 yellow.
  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync2_q, level_q, level_prev_q, press_q;
  logic [DbW-1:0] db_cnt_q [3];

  assign raw = {yellow_button, blue_button, red_button};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            level_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic red_press, blue_press, yellow_press;
  assign red_press    = press_q[0];
  assign blue_press   = press_q[1];
  assign yellow_press = press_q[2];

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      confirm_q, confirm_d;
  logic            start_q, start_d;
  logic [RdyW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StMenu;
      sel_q     <= '0;
      confirm_q <= '0;
      start_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      confirm_q <= confirm_d;
      start_q   <= start_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    confirm_d = confirm_q;
    start_d   = 1'b0;
    count_d   = count_q;
    unique case (state_q)
      StMenu: begin
        confirm_d = '0;
        // Yellow takes priority; red and blue together cancel out.
        if (yellow_press) begin
          state_d   = StReady;
          confirm_d = sel_q + 2'd1;
          count_d   = RdyLast;
        end else if (red_press && !blue_press) begin
          sel_d = (sel_q == 2'd0) ? SelLast : sel_q - 2'd1;
        end else if (blue_press && !red_press) begin
          sel_d = (sel_q == SelLast) ? 2'd0 : sel_q + 2'd1;
        end
      end
      StReady: begin
        if (count_q == '0) begin
          state_d = StPlay;
          start_d = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StPlay: begin
        if (finish) state_d = StResult;
      end
      StResult: begin
        if (yellow_press) begin
          state_d   = StMenu;
          confirm_d = '0;
        end
      end
    endcase
  end

  assign state        = state_q;
  assign song_sel     = sel_q;
  assign song_confirm = confirm_q;
  assign start        = start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a randomized menu walk against a
// modular-arithmetic model of the song selection and game mode.
module tb_game_flow_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned R = 8;
  localparam int unsigned N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       red = 1'b0, blue = 1'b0, yellow = 1'b0, finish = 1'b0;
  logic [1:0] state, song_sel, song_confirm;
  logic       start;

  int total = 0;
  int bad   = 0;
  int m_sel = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .READY_CYCLES   (R),
    .NUM_SONGS      (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .red_button   (red),
    .blue_button  (blue),
    .yellow_button(yellow),
    .finish       (finish),
    .state        (state),
    .song_sel     (song_sel),
    .song_confirm (song_confirm),
    .start        (start)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    red = 0; blue = 0; yellow = 0; finish = 0;
    rst = 1;
    tick(2);
    rst = 0;
    m_sel = 0;
  endtask

  // Hold a clean press long enough to register, then release and let the release settle.
  task automatic press(input logic r, input logic b, input logic y);
    red = r; blue = b; yellow = y;
    tick(D + 4);
    red = 0; blue = 0; yellow = 0;
    tick(D + 4);
  endtask

  task automatic test_reset();
    red = 0; blue = 0; yellow = 0; finish = 0;
    rst = 1;
    tick(3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (song_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", song_sel); end
    total++; if (song_confirm !== 2'd0) begin bad++; $display("FAIL reset_confirm got=%0d want=0", song_confirm); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0d want=0", start); end
    rst = 0;
    m_sel = 0;
  endtask

  task automatic test_debounce();
    do_reset();
    blue = 1; tick(3); blue = 0; tick(12);
    total++; if (song_sel !== 2'd0) begin bad++; $display("FAIL glitch got=%0d want=0", song_sel); end
    blue = 1;
    tick(D + 3);
    total++; if (song_sel !== 2'd0) begin bad++; $display("FAIL latency_early got=%0d want=0", song_sel); end
    tick(1);
    total++; if (song_sel !== 2'd1) begin bad++; $display("FAIL latency_edge got=%0d want=1", song_sel); end
    tick(2);
    blue = 0;
    tick(12);
    total++; if (song_sel !== 2'd1) begin bad++; $display("FAIL single_inc got=%0d want=1", song_sel); end
    m_sel = 1;
  endtask

  task automatic test_reset_held();
    red = 1; rst = 1;
    tick(2);
    rst = 0;
    tick(D + 3);
    total++; if (song_sel !== 2'd0) begin bad++; $display("FAIL held_early got=%0d want=0", song_sel); end
    tick(1);
    m_sel = (0 + N - 1) % N;
    total++; if (song_sel !== 2'(m_sel)) begin bad++; $display("FAIL held_press got=%0d want=%0d", song_sel, m_sel); end
    red = 0;
    tick(D + 4);
  endtask

  task automatic test_menu_nav();
    do_reset();
    press(1, 0, 0); m_sel = (m_sel + N - 1) % N;
    total++; if (song_sel !== 2'(m_sel)) begin bad++; $display("FAIL red_wrap got=%0d want=%0d", song_sel, m_sel); end
    press(0, 1, 0); m_sel = (m_sel + 1) % N;
    press(0, 1, 0); m_sel = (m_sel + 1) % N;
    total++; if (song_sel !== 2'(m_sel)) begin bad++; $display("FAIL blue_twice got=%0d want=%0d", song_sel, m_sel); end
    press(1, 1, 0);
    total++; if (song_sel !== 2'(m_sel)) begin bad++; $display("FAIL red_blue got=%0d want=%0d", song_sel, m_sel); end
    total++; if (state !== 2'd0 || song_confirm !== 2'd0) begin
      bad++; $display("FAIL menu_mode got=%0d/%0d want=0/0", state, song_confirm);
    end
  endtask

  task automatic test_ready_play();
    press(0, 1, 0); m_sel = (m_sel + 1) % N;
    total++; if (song_sel !== 2'(m_sel)) begin bad++; $display("FAIL pre_ready_sel got=%0d want=%0d", song_sel, m_sel); end
    yellow = 1;
    tick(D + 3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL yellow_early got=%0d want=0", state); end
    tick(1);
    yellow = 0;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL enter_ready got=%0d want=1", state); end
    total++; if (song_confirm !== 2'(m_sel + 1)) begin
      bad++; $display("FAIL ready_confirm got=%0d want=%0d", song_confirm, m_sel + 1);
    end
    // Presses and finish during the countdown must not disturb it.
    red = 1; finish = 1;
    for (int i = 1; i < R; i++) begin
      tick(1);
      if (i == 3) finish = 0;
      total++; if (state !== 2'd1 || start !== 1'b0) begin
        bad++; $display("FAIL countdown_%0d got=%0d/%0d want=1/0", i, state, start);
      end
    end
    tick(1);
    total++; if (state !== 2'd2 || start !== 1'b1) begin
      bad++; $display("FAIL play_start got=%0d/%0d want=2/1", state, start);
    end
    total++; if (song_sel !== 2'(m_sel)) begin bad++; $display("FAIL ready_ignore got=%0d want=%0d", song_sel, m_sel); end
    tick(1);
    total++; if (state !== 2'd2 || start !== 1'b0) begin
      bad++; $display("FAIL start_once got=%0d/%0d want=2/0", state, start);
    end
    red = 0;
    tick(D + 4);
  endtask

  task automatic test_play_result();
    press(0, 1, 0);
    total++; if (state !== 2'd2 || song_sel !== 2'(m_sel)) begin
      bad++; $display("FAIL play_ignore got=%0d/%0d want=2/%0d", state, song_sel, m_sel);
    end
    finish = 1; tick(1); finish = 0;
    total++; if (state !== 2'd3 || song_confirm !== 2'(m_sel + 1)) begin
      bad++; $display("FAIL to_result got=%0d/%0d want=3/%0d", state, song_confirm, m_sel + 1);
    end
    finish = 1;
    press(1, 1, 0);
    finish = 0;
    total++; if (state !== 2'd3 || song_sel !== 2'(m_sel)) begin
      bad++; $display("FAIL result_ignore got=%0d/%0d want=3/%0d", state, song_sel, m_sel);
    end
    press(0, 0, 1);
    total++; if (state !== 2'd0 || song_confirm !== 2'd0 || song_sel !== 2'(m_sel)) begin
      bad++; $display("FAIL back_to_menu got=%0d/%0d/%0d want=0/0/%0d", state, song_confirm, song_sel, m_sel);
    end
  endtask

  // From READY: wait (bounded) for the start pulse, finish in the first PLAY cycle, return home.
  task automatic finish_round(input string tag);
    int k = 0;
    while (start !== 1'b1 && k < int'(R) + 4) begin
      tick(1);
      k++;
    end
    total++; if (start !== 1'b1 || state !== 2'd2) begin
      bad++; $display("FAIL %s_start got=%0d/%0d want=1/2", tag, start, state);
    end
    finish = 1; tick(1); finish = 0;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL %s_first_finish got=%0d want=3", tag, state); end
    press(0, 0, 1);
    total++; if (state !== 2'd0 || song_confirm !== 2'd0) begin
      bad++; $display("FAIL %s_home got=%0d/%0d want=0/0", tag, state, song_confirm);
    end
  endtask

  task automatic test_red_yellow();
    red = 1; yellow = 1;
    tick(D + 4);
    red = 0; yellow = 0;
    total++; if (state !== 2'd1 || song_confirm !== 2'(m_sel + 1) || song_sel !== 2'(m_sel)) begin
      bad++; $display("FAIL red_yellow got=%0d/%0d/%0d want=1/%0d/%0d",
                      state, song_confirm, song_sel, m_sel + 1, m_sel);
    end
    finish_round("ry");
  endtask

  task automatic test_reset_mid_ready();
    int seen = 0;
    yellow = 1; tick(D + 4); yellow = 0;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL mid_ready_enter got=%0d want=1", state); end
    tick(R - 3);
    rst = 1; tick(1);
    total++; if (state !== 2'd0 || song_confirm !== 2'd0 || song_sel !== 2'd0) begin
      bad++; $display("FAIL mid_ready_rst got=%0d/%0d/%0d want=0/0/0", state, song_confirm, song_sel);
    end
    rst = 0; m_sel = 0;
    for (int i = 0; i < int'(R) + 4; i++) begin
      if (start !== 1'b0 || state !== 2'd0) seen++;
      tick(1);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_ready_quiet got=%0d want=0", seen); end
  endtask

  task automatic test_random();
    logic r, b;
    for (int it = 0; it < 24; it++) begin
      r = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        red = r; blue = b; yellow = 1;
        tick(D + 4);
        red = 0; blue = 0; yellow = 0;
        total++; if (state !== 2'd1 || song_confirm !== 2'(m_sel + 1) || song_sel !== 2'(m_sel)) begin
          bad++; $display("FAIL rnd_ready_%0d got=%0d/%0d/%0d want=1/%0d/%0d",
                          it, state, song_confirm, song_sel, m_sel + 1, m_sel);
        end
        finish_round("rnd");
      end else begin
        press(r, b, 1'b0);
        if (r && !b) m_sel = (m_sel + N - 1) % N;
        else if (b && !r) m_sel = (m_sel + 1) % N;
        total++; if (song_sel !== 2'(m_sel) || state !== 2'd0 || song_confirm !== 2'd0) begin
          bad++; $display("FAIL rnd_menu_%0d got=%0d/%0d/%0d want=%0d/0/0",
                          it, song_sel, state, song_confirm, m_sel);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_reset_held();
    test_menu_nav();
    test_ready_play();
    test_play_result();
    test_red_yellow();
    test_reset_mid_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
